wb_ctrl: RTL and testbench
==========================

Name: wb_ctrl

Overview:
- Write-back controller: the producer-side driver of the register file's single write port (wb_en / wb_addr / wr_data).
- Accepts results from two sources, the ALU and the load path, up to two per cycle.
- Buffers them in a small in-order queue and drains one per cycle to the register file.
- Provides per-operand pending (busy) status and forwarding data for the ra / rb read addresses, so the issue logic can stall or bypass.

Parameters:
- DW, 8, data width of register contents.
- AW, 2, register address width (2**AW registers).
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- flash  input  1  Flush: discard all queued, not-yet-written results.
- alu_valid  input  1  ALU result present.
- alu_addr  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- ld_valid  input  1  Load result present.
- ld_addr  input  AW  Load destination register.
- ld_data  input  DW  Load result.
- ld_ready  output  1  Load result accepted this cycle when ld_valid is also high.
- wb_en  output  1  Register-file write enable (registered).
- wb_addr  output  AW  Write address (registered).
- wr_data  output  DW  Write data (registered).
- ra  input  AW  Operand A read address, from issue.
- rb  input  AW  Operand B read address, from issue.
- ra_busy  output  1  A queued entry targets ra.
- rb_busy  output  1  A queued entry targets rb.
- ra_fwd  output  DW  Data of the youngest queued entry targeting ra; 0 when not busy.
- rb_fwd  output  DW  Data of the youngest queued entry targeting rb; 0 when not busy.

Behaviour:
- Reset (rst high at an edge): queue emptied (count = 0, head = tail = 0); wb_en = 0; wb_addr = 0; wr_data = 0. rst overrides flash and all valids.
- Ready rules, based on the registered count only (no valid->ready combinational path):
  - alu_ready = !flash && count <= DEPTH-1.
  - ld_ready = !flash && count <= DEPTH-2.
  - The same-cycle drain is not credited.
- Accept: a source is accepted on the edge where valid && ready.
  - Both accepted in the same cycle: the ALU entry is written first (older), then the load entry; tail advances by 2.
- Drain: on every edge where count > 0 (and no flash/rst), the head entry is popped into wb_addr / wr_data and wb_en = 1 for the following cycle; otherwise wb_en = 0 (wb_addr / wr_data hold).
- Latency: a result accepted at edge N is presented on wb_* after edge N+1 at the earliest; one entry is written per cycle.
- Count update: count_next = count + accepted - popped. A pop and up to two pushes may occur on the same edge. Pointers wrap modulo DEPTH.
- Busy / forward are combinational over valid queue entries only.
  - The entry currently on wb_* is not busy, because the register file write completes in that cycle.
  - With multiple matches, forward the youngest entry (closest to tail).
  - Incoming alu/ld inputs of the current cycle are not included.
- Flush (flash high, rst low): at the edge, count = 0, head = tail = 0, wb_en = 0. Same-cycle valids are dropped, since ready is low.
- Full: count = DEPTH gives alu_ready = ld_ready = 0. A pop still occurs at that edge, and readiness returns the next cycle.
- Ordering: register-file writes occur in exact acceptance order; two writes to the same register both occur, and the last one wins.

Decomposition:
- Package wb_pkg: DW, AW, DEPTH defaults; wb_entry_t typedef {addr[AW], data[DW]}; CNT_W = clog2(DEPTH+1).
- One sub-module, wb_fifo: 2-push / 1-pop circular buffer exposing count and all entries with valid bits for the busy/forward scan.
- wb_ctrl contains the ready logic, output registers and busy/forward priority scan.

Test Plan:
- Reset: assert rst 2 cycles with alu_valid = 1 -> wb_en = 0, wb_addr = 0, wr_data = 0, alu_ready = 1, ld_ready = 1 after release.
- Single ALU result: alu_addr = 2, alu_data = 8'h5A accepted at edge N -> wb_en = 1, wb_addr = 2, wr_data = 8'h5A after edge N+1; wb_en = 0 after N+2; ra = 2 gives ra_busy = 1, ra_fwd = 8'h5A only between edges N and N+1.
- Dual accept: ALU (r1, 8'h11) and load (r1, 8'h22) in the same cycle -> rb = 1 gives rb_fwd = 8'h22; writes appear in order r1 = 8'h11 then r1 = 8'h22 on consecutive cycles.
- Full / backpressure: hold both valids with DEPTH = 4 -> ld_ready drops at count >= 3 and alu_ready at count = 4; no entry lost or duplicated; drained sequence matches accepted order.
- Flush: queue 3 entries, assert flash for 1 cycle with alu_valid = 1 -> alu_ready = 0 that cycle; wb_en = 0 next cycle; no queued entry is ever written; ra_busy = 0.
- Wrap-around: stream 10 single ALU results (r0..r3 cyclic, data 0..9) -> wb_* shows data 0..9 in order with pointer wrap and no gaps beyond backpressure.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults and entry type for the write-back controller
package wb_pkg;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-push / 1-pop circular buffer exposing every entry for the busy/forward scan
module wb_fifo #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  input  logic          push1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [PW-1:0] head,
  output logic [AW-1:0] ent_addr [DEPTH],
  output logic [DW-1:0] ent_data [DEPTH],
  output logic [DEPTH-1:0] ent_valid
);
  logic [PW-1:0] tail, tail1;
  assign tail1 = tail + PW'(push0);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail1 + PW'(push1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
  // push1 lands behind push0 when both arrive together, keeping acceptance order
  always_ff @(posedge clk) begin
    if (push0) begin
      ent_addr[tail] <= addr0;
      ent_data[tail] <= data0;
    end
    if (push1) begin
      ent_addr[tail1] <= addr1;
      ent_data[tail1] <= data1;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_v
    logic [PW-1:0] off;
    assign off = PW'(i) - head;
    assign ent_valid[i] = CW'(off) < count;
  end
endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: queues ALU/load results and drains one per cycle to the register-file write port
module wb_ctrl import wb_pkg::*; #(
  parameter int DW = wb_pkg::DW,
  parameter int AW = wb_pkg::AW,
  parameter int DEPTH = wb_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flash,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          ra_busy,
  output logic          rb_busy,
  output logic [DW-1:0] ra_fwd,
  output logic [DW-1:0] rb_fwd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic [PW-1:0] head, idx;
  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic pop;
  // readiness looks only at the registered count; the same-cycle pop is not credited
  assign alu_ready = !flash && count <= CW'(DEPTH - 1);
  assign ld_ready  = !flash && count <= CW'(DEPTH - 2);
  assign pop       = !flash && count != '0;
  wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_fifo (
    .clk(clk), .rst(rst), .flush(flash),
    .push0(alu_valid && alu_ready), .addr0(alu_addr), .data0(alu_data),
    .push1(ld_valid && ld_ready), .addr1(ld_addr), .data1(ld_data),
    .pop(pop), .count(count), .head(head),
    .ent_addr(ent_addr), .ent_data(ent_data), .ent_valid(ent_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wr_data <= '0;
    end else begin
      wb_en <= pop;
      if (pop) begin
        wb_addr <= ent_addr[head];
        wr_data <= ent_data[head];
      end
    end
  end
  // walk oldest to youngest so the last match wins
  always_comb begin
    ra_busy = 1'b0;
    rb_busy = 1'b0;
    ra_fwd  = '0;
    rb_fwd  = '0;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_valid[idx] && ent_addr[idx] == ra) begin
        ra_busy = 1'b1;
        ra_fwd  = ent_data[idx];
      end
      if (ent_valid[idx] && ent_addr[idx] == rb) begin
        rb_busy = 1'b1;
        rb_fwd  = ent_data[idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: table-driven and sequence checks of the write-back controller
module tb_wb_ctrl;
  import wb_pkg::*;
  logic clk, rst, flash;
  logic alu_valid, ld_valid, alu_ready, ld_ready;
  logic [1:0] alu_addr, ld_addr, ra, rb, wb_addr;
  logic [7:0] alu_data, ld_data, wr_data, ra_fwd, rb_fwd;
  logic wb_en, ra_busy, rb_busy;
  int total = 0, passed = 0, writes = 0, accepted = 0, sent = 0, guard = 0;
  wb_entry_t q[$];
  logic e_wen;
  logic [1:0] e_wa;
  logic [7:0] e_wd;
  logic acc;

  typedef struct {
    logic fl, av; logic [1:0] aa; logic [7:0] ad;
    logic lv; logic [1:0] la; logic [7:0] ld;
    logic [1:0] ra, rb;
    logic ar, lr, rab; logic [7:0] raf; logic rbb; logic [7:0] rbf;
    logic wen; logic [1:0] wa; logic [7:0] wd;
  } vec_t;
  vec_t tbl [8];

  wb_ctrl dut (
    .clk(clk), .rst(rst), .flash(flash),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wr_data(wr_data),
    .ra(ra), .rb(rb), .ra_busy(ra_busy), .rb_busy(rb_busy), .ra_fwd(ra_fwd), .rb_fwd(rb_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic fl, input logic av, input logic [1:0] aa, input logic [7:0] ad,
                       input logic lv, input logic [1:0] la, input logic [7:0] ld,
                       input logic [1:0] a, input logic [1:0] b);
    flash = fl; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ld; ra = a; rb = b;
  endtask

  function automatic logic [8:0] look(input logic [1:0] r);
    logic [8:0] res = '0;
    foreach (q[i]) if (q[i].addr == r) res = {1'b1, q[i].data};
    return res;
  endfunction

  // one cycle against the queue-level reference model
  task automatic step(input logic fl, input logic av, input logic [1:0] aa, input logic [7:0] ad,
                      input logic lv, input logic [1:0] la, input logic [7:0] ld,
                      input logic [1:0] a, input logic [1:0] b, output logic acc_a);
    int n;
    logic acc_l;
    logic [8:0] ea, eb;
    wb_entry_t e;
    @(negedge clk);
    drive(fl, av, aa, ad, lv, la, ld, a, b);
    #1;
    n = q.size();
    ea = look(a);
    eb = look(b);
    chk("alu_ready", alu_ready, !fl && n <= 3);
    chk("ld_ready", ld_ready, !fl && n <= 2);
    chk("ra_busy", ra_busy, ea[8]);
    chk("ra_fwd", ra_fwd, ea[7:0]);
    chk("rb_busy", rb_busy, eb[8]);
    chk("rb_fwd", rb_fwd, eb[7:0]);
    chk("wb_en", wb_en, e_wen);
    chk("wb_addr", wb_addr, e_wa);
    chk("wr_data", wr_data, e_wd);
    if (wb_en) writes++;
    acc_a = av && !fl && n <= 3;
    acc_l = lv && !fl && n <= 2;
    if (fl) begin
      q.delete();
      e_wen = 1'b0;
    end else begin
      e_wen = n > 0;
      if (n > 0) begin
        e = q.pop_front();
        e_wa = e.addr;
        e_wd = e.data;
      end
      if (acc_a) begin q.push_back('{aa, ad}); accepted++; end
      if (acc_l) begin q.push_back('{la, ld}); accepted++; end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1, 3, 8'hFF, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("rst wb_en", wb_en, 0);
    chk("rst wb_addr", wb_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst alu_ready", alu_ready, 1);
    chk("rst ld_ready", ld_ready, 1);

    tbl[0] = '{0,1,2,'h5A,0,0,0, 2,0, 1,1,0,0,0,0,0,0,0};
    tbl[1] = '{0,0,0,0,0,0,0, 2,2, 1,1,1,'h5A,1,'h5A,0,0,0};
    tbl[2] = '{0,0,0,0,0,0,0, 2,0, 1,1,0,0,0,0,1,2,'h5A};
    tbl[3] = '{0,1,1,'h11,1,1,'h22, 0,1, 1,1,0,0,0,0,0,2,'h5A};
    tbl[4] = '{0,0,0,0,0,0,0, 1,1, 1,1,1,'h22,1,'h22,0,2,'h5A};
    tbl[5] = '{0,0,0,0,0,0,0, 1,0, 1,1,1,'h22,0,0,1,1,'h11};
    tbl[6] = '{0,0,0,0,0,0,0, 1,1, 1,1,0,0,0,0,1,1,'h22};
    tbl[7] = '{0,0,0,0,0,0,0, 0,0, 1,1,0,0,0,0,0,1,'h22};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("v%0d alu_ready", i), alu_ready, tbl[i].ar);
      chk($sformatf("v%0d ld_ready", i), ld_ready, tbl[i].lr);
      chk($sformatf("v%0d ra_busy", i), ra_busy, tbl[i].rab);
      chk($sformatf("v%0d ra_fwd", i), ra_fwd, tbl[i].raf);
      chk($sformatf("v%0d rb_busy", i), rb_busy, tbl[i].rbb);
      chk($sformatf("v%0d rb_fwd", i), rb_fwd, tbl[i].rbf);
      chk($sformatf("v%0d wb_en", i), wb_en, tbl[i].wen);
      chk($sformatf("v%0d wb_addr", i), wb_addr, tbl[i].wa);
      chk($sformatf("v%0d wr_data", i), wr_data, tbl[i].wd);
    end
    e_wen = 1'b0; e_wa = 2'd1; e_wd = 8'h22;

    writes = 0; accepted = 0;
    for (int i = 0; i < 12; i++)
      step(0, 1, 2'(i), 8'(8'h40 + i), 1, 2'(i + 1), 8'(8'h80 + i), 2'(i), 2'(i + 1), acc);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 1, acc);
    chk("bp writes", writes, accepted);

    writes = 0;
    step(0, 1, 0, 8'hA1, 1, 1, 8'hA2, 0, 1, acc);
    step(0, 1, 2, 8'hA3, 1, 3, 8'hA4, 1, 3, acc);
    step(1, 1, 3, 8'hEE, 0, 0, 0, 3, 2, acc);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 3, 2, acc);
    chk("flush writes", writes, 1);

    writes = 0; sent = 0; guard = 0;
    while (sent < 10 && guard < 40) begin
      step(0, 1, 2'(sent), 8'(sent), 0, 0, 0, 2'(sent), 2'(sent + 3), acc);
      if (acc) sent++;
      guard++;
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("wrap sent", sent, 10);
    chk("wrap writes", writes, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
